// File: rtl/mem_responder_if.sv
// Core-side single-port memory bus: one request at a time, completion signalled by a
// one-cycle mem_resp pulse.
interface mem_responder_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word-addressed memory responder mapped at BASE_ADDR, with a side-band
// preload port usable while the core is held in reset.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1000,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_responder_if.slave        bus,
  input  logic                  load_en,
  input  logic [31:0]           load_addr,
  input  logic [31:0]           load_data,
  output logic                  err
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = BASE_ADDR + 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             is_wr_q, is_wr_d;
  logic             in_range_q, in_range_d;
  logic             err_q, err_d;

  logic [31:0]      ram [DEPTH_WORDS];
  logic [31:0]      ram_rd_q;
  logic             ram_we;
  logic [IDX_W-1:0] ram_wr_idx, ram_rd_idx;
  logic [31:0]      ram_wdata;

  logic [31:0]      req_off, load_off;
  logic [IDX_W-1:0] req_idx, load_idx;
  logic             req_in_range, load_in_range;
  logic             unused_off_bits;

  // Byte offset from the base; the low two bits are the ignored byte lane.
  assign req_off       = bus.mem_addr - BASE_ADDR;
  assign load_off      = load_addr - BASE_ADDR;
  assign req_idx       = req_off[IDX_W+1:2];
  assign load_idx      = load_off[IDX_W+1:2];
  assign req_in_range  = (bus.mem_addr >= BASE_ADDR) && (bus.mem_addr < ADDR_LIMIT);
  assign load_in_range = (load_addr >= BASE_ADDR) && (load_addr < ADDR_LIMIT);
  assign unused_off_bits = ^{req_off[31:IDX_W+2], req_off[1:0],
                             load_off[31:IDX_W+2], load_off[1:0]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      in_range_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      is_wr_q    <= is_wr_d;
      in_range_q <= in_range_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    in_range_d = in_range_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (!load_en && (bus.mem_read || bus.mem_write)) begin
          idx_d      = req_idx;
          wdata_d    = bus.mem_wdata;
          is_wr_d    = bus.mem_write;
          in_range_d = req_in_range;
          cnt_d      = CNT_INIT;
          state_d    = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        if (!in_range_q) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single write port shared by preload (IDLE only) and the core write commit (RESP).
  always_comb begin
    ram_we     = 1'b0;
    ram_wr_idx = load_idx;
    ram_wdata  = load_data;
    if (state_q == IDLE && load_en && load_in_range) begin
      ram_we = 1'b1;
    end else if (state_q == RESP && is_wr_q && in_range_q) begin
      ram_we     = 1'b1;
      ram_wr_idx = idx_q;
      ram_wdata  = wdata_q;
    end
    // Read one cycle ahead so the registered data lands exactly in RESP.
    ram_rd_idx = (state_q == IDLE) ? req_idx : idx_q;
  end

  // NOTE: the storage array and its read register have no reset so they map onto
  // block RAM; contents survive rst_n by design.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_wr_idx] <= ram_wdata;
    ram_rd_q <= ram[ram_rd_idx];
  end

  always_comb begin
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    if (state_q == RESP) begin
      bus.mem_resp = 1'b1;
      if (!is_wr_q) bus.mem_rdata = in_range_q ? ram_rd_q : ERR_DATA;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: table-driven transactions on a LATENCY=2 instance plus
// hand sequences for preload priority, reset mid-write and LATENCY=1/15 instances.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        err0, err1, err2;

  int n_checks = 0;
  int n_pass   = 0;

  mem_responder_if b0();
  mem_responder_if b1();
  mem_responder_if b2();

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .bus(b0),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .err(err0)
  );
  mem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .bus(b1),
    .load_en(1'b0), .load_addr(32'h0), .load_data(32'h0), .err(err1)
  );
  mem_responder #(.DEPTH_WORDS(16), .LATENCY(15)) u_l15 (
    .clk(clk), .rst_n(rst_n), .bus(b2),
    .load_en(1'b0), .load_addr(32'h0), .load_data(32'h0), .err(err2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input int w, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    case (w)
      0: begin b0.mem_read = rd; b0.mem_write = wr; b0.mem_addr = a; b0.mem_wdata = d; end
      1: begin b1.mem_read = rd; b1.mem_write = wr; b1.mem_addr = a; b1.mem_wdata = d; end
      default: begin b2.mem_read = rd; b2.mem_write = wr; b2.mem_addr = a; b2.mem_wdata = d; end
    endcase
  endtask

  function automatic logic resp_of(input int w);
    case (w)
      0: return b0.mem_resp;
      1: return b1.mem_resp;
      default: return b2.mem_resp;
    endcase
  endfunction

  function automatic logic [31:0] rdata_of(input int w);
    case (w)
      0: return b0.mem_rdata;
      1: return b1.mem_rdata;
      default: return b2.mem_rdata;
    endcase
  endfunction

  // Drives one request from a negedge, holds it until mem_resp, then drops it.
  // lat is the number of negedges from the drive to the mem_resp sample (-1 on timeout).
  task automatic req(input int w, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] got, output int lat);
    @(negedge clk);
    drive(w, rd, wr, a, d);
    lat = -1;
    got = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (resp_of(w)) begin
        lat = i;
        got = rdata_of(w);
        break;
      end
    end
    drive(w, 1'b0, 1'b0, a, d);
  endtask

  // Write the last word, read it back, then hold a read to see the re-acceptance timing.
  task automatic latency_test(input int w, input int lat_exp, input logic [31:0] last_addr);
    logic [31:0] got;
    int          lat, first, second;
    req(w, 1'b0, 1'b1, last_addr, 32'h0F0F0F0F, got, lat);
    check($sformatf("L%0d write latency", lat_exp), 32'(lat), 32'(lat_exp));
    @(negedge clk);
    check($sformatf("L%0d resp drop", lat_exp), {31'b0, resp_of(w)}, 32'd0);
    drive(w, 1'b1, 1'b0, last_addr, 32'h0);
    first  = -1;
    second = -1;
    got    = '0;
    for (int i = 1; i <= 2 * lat_exp + 6; i++) begin
      @(negedge clk);
      if (resp_of(w)) begin
        if (first < 0) begin
          first = i;
          got   = rdata_of(w);
        end else begin
          second = i;
          break;
        end
      end
    end
    drive(w, 1'b0, 1'b0, last_addr, 32'h0);
    check($sformatf("L%0d held first resp", lat_exp), 32'(first), 32'(lat_exp));
    check($sformatf("L%0d held second resp", lat_exp), 32'(second), 32'(2 * lat_exp + 1));
    check($sformatf("L%0d read data", lat_exp), got, 32'h0F0F0F0F);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] got;
    int          lat;
    int          resp_seen;

    vecs[0]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         32'h0050_0093, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_1004, 32'h0,         32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_1010, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_1012, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 32'h0000_1014, 32'h1111_2222, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_1014, 32'h0,         32'h1111_2222, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_1FFC, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_1FFF, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         32'hDEAD_BEEF, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_2000, 32'h5555_5555, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         32'h0050_0093, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         32'hDEAD_BEEF, 1'b1};

    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state, then preload while the core side is held in reset.
    @(negedge clk);
    check("reset mem_resp", {31'b0, b0.mem_resp}, 32'd0);
    check("reset mem_rdata", b0.mem_rdata, 32'd0);
    check("reset err", {31'b0, err0}, 32'd0);
    load_en = 1'b1; load_addr = 32'h1000; load_data = 32'h0050_0093;
    @(negedge clk);
    load_addr = 32'h1004; load_data = 32'h0;
    @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      req(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, got, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
      check($sformatf("vec%0d rdata", i), got, vecs[i].exp_rdata);
      @(negedge clk);
      check($sformatf("vec%0d resp drop", i), {31'b0, b0.mem_resp}, 32'd0);
      check($sformatf("vec%0d err", i), {31'b0, err0}, {31'b0, vecs[i].exp_err});
    end

    // Preload and read in the same IDLE cycle: read accepted one cycle later.
    @(negedge clk);
    load_en = 1'b1; load_addr = 32'h1020; load_data = 32'hA5A5_0001;
    drive(0, 1'b1, 1'b0, 32'h1020, 32'h0);
    lat = -1;
    got = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      load_en = 1'b0;
      if (b0.mem_resp) begin
        lat = i;
        got = b0.mem_rdata;
        break;
      end
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("priority latency", 32'(lat), 32'd3);
    check("priority rdata", got, 32'hA5A5_0001);
    @(negedge clk);
    check("priority resp drop", {31'b0, b0.mem_resp}, 32'd0);

    // Reset during BUSY discards the pending write.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h1004, 32'h1234_5678);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    resp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b0.mem_resp) resp_seen++;
      if (i == 1) rst_n = 1'b1;
    end
    check("reset mid-write resp count", 32'(resp_seen), 32'd0);
    check("reset clears err", {31'b0, err0}, 32'd0);
    req(0, 1'b1, 1'b0, 32'h1004, 32'h0, got, lat);
    check("reset mid-write readback", got, 32'h0);
    check("reset mid-write latency", 32'(lat), 32'd2);
    @(negedge clk);

    latency_test(1, 1, 32'h103C);
    latency_test(2, 15, 32'h103C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's single-port memory interface (mem_addr, mem_wdata, mem_read, mem_write, mem_rdata, mem_resp).
- Holds a word-addressed storage array mapped at BASE_ADDR.
- Services one read or write at a time with a fixed, parameterised latency and pulses mem_resp for exactly one cycle per request.
- Includes a side-band preload port so benches and boot logic can fill program memory while the core is held in reset.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
- BASE_ADDR, 32'h1000, byte address of word 0; matches the core PC reset value.
- LATENCY, 2, cycles from request acceptance to mem_resp (legal range 1..15).
- ERR_DATA, 32'hDEADBEEF, read data returned for an out-of-range address.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- mem_addr  input  32  byte address from core MAR
- mem_wdata  input  32  write data from core MDR
- mem_read  input  1  read request, held by core until mem_resp
- mem_write  input  1  write request, held by core until mem_resp
- mem_rdata  output  32  read data, valid only while mem_resp=1 on a read
- mem_resp  output  1  one-cycle completion pulse
- load_en  input  1  preload write strobe
- load_addr  input  32  preload byte address
- load_data  input  32  preload word
- err  output  1  sticky out-of-range flag

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - mem_resp=0, mem_rdata=0, err=0.
  - FSM=IDLE, latency counter=0.
  - Array contents are not reset and are retained across reset.
- Address decode:
  - word index = (addr - BASE_ADDR) >> 2; addr[1:0] is ignored.
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS, using unsigned 32-bit compare.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If load_en=1: write load_data to the array at the load_addr index. Ignored if out of range; err is not set.
  - Else, if mem_read or mem_write is 1: capture addr, wdata and op, load the counter with LATENCY-1, and go to BUSY. If LATENCY=1, go directly to RESP.
  - load_en has priority over core requests. A core request that is still held is sampled on the next IDLE cycle.
- BUSY: decrement the counter; go to RESP when the counter reaches 0.
- RESP (exactly one cycle, then IDLE):
  - mem_resp=1.
  - Read in range: mem_rdata = array[idx].
  - Write in range: array[idx] <= captured wdata at the end of this cycle.
  - Out of range: a read returns ERR_DATA, a write is dropped, and err is set. err stays set until reset.
  - In all other cycles mem_rdata is 0.
- Latency: a request first visible in IDLE cycle t produces mem_resp in cycle t+LATENCY.
- Back-to-back requests: the earliest next acceptance is cycle t+LATENCY+1, since RESP always returns to IDLE.
  - A request still asserted in that IDLE cycle is treated as a new request. The core must drop or change its request in the cycle after mem_resp.
- mem_read and mem_write both 1: treated as a write; mem_rdata=0 in RESP.
- Request inputs are sampled only in IDLE. Changes to mem_addr or mem_wdata during BUSY have no effect.
- load_en outside IDLE: ignored.
- Reset asserted in BUSY or RESP:
  - Immediate return to IDLE with mem_resp=0.
  - A pending write is discarded and the array is unchanged.
- Storage is a single-write-port, single-read-port array, suitable for FPGA block RAM.

Test Plan:
- Preload then fetch: load 32'h00500093 at 0x1000 with rst_n=0, release reset, mem_read with addr=0x1000 (LATENCY=2) -> mem_resp high exactly 2 cycles after the request is seen, mem_rdata=32'h00500093, mem_resp low the next cycle.
- Write then read: mem_write addr=0x1010 wdata=32'hCAFEF00D, then mem_read addr=0x1012 -> read returns 32'hCAFEF00D (addr[1:0] ignored); one mem_resp pulse per request.
- Out of range: mem_read addr=0x0FFC -> mem_rdata=32'hDEADBEEF, err=1. mem_write addr=0x1000+4*DEPTH_WORDS -> dropped, err stays 1, array unchanged.
- Latency sweep LATENCY=1 and LATENCY=15 -> mem_resp at t+1 and t+15 respectively; a held request re-accepted at t+LATENCY+1.
- Reset mid-write: mem_write addr=0x1004 wdata=32'h12345678 (old contents 32'h0) with rst_n pulsed low in BUSY -> mem_resp never asserts, a later read of 0x1004 returns 32'h0.
- Priority: load_en and mem_read in the same IDLE cycle -> preload written first, read accepted one cycle later, read latency measured from acceptance.
